// File: rtl/arb_n_avlstrm.sv
// arb_n_avlstrm
//   N-input round-robin arbiter for valid/ready streams. Each input owns a
//   DEPTH-entry FIFO. A registered output stage merges the FIFOs onto one
//   stream, and each output beat is tagged with its source channel.
//
//   Optional feature (compile-time macro ARB_N_PKT_LOCK_EN):
//     defined   - packet lock. A channel keeps the grant from the first beat
//                 of a packet until the beat carrying last=1.
//     undefined - beat interleave. The arbiter re-arbitrates on every beat.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_data    NUM_IN*DWIDTH input data; channel i at [i*DWIDTH +: DWIDTH]
//     in_valid   per-channel valid
//     in_last    per-channel end-of-packet flag
//     in_ready   per-channel ready (FIFO not full; low during reset)
//     out_data   output beat data
//     out_valid  output beat valid
//     out_last   output beat end-of-packet flag
//     out_chan   source channel of the output beat
//     out_ready  downstream ready
module arb_n_avlstrm #(
   parameter int NUM_IN = 4,
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 1024,
   parameter int CW     = $clog2(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_IN*DWIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]        in_valid,
   input  logic [NUM_IN-1:0]        in_last,
   output logic [NUM_IN-1:0]        in_ready,
   output logic [DWIDTH-1:0]        out_data,
   output logic                     out_valid,
   output logic                     out_last,
   output logic [CW-1:0]            out_chan,
   input  logic                     out_ready
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   // FIFO storage holds {last, data}
   logic [DWIDTH:0]   mem      [NUM_IN][DEPTH];
   logic [AW-1:0]     wr_ptr   [NUM_IN];
   logic [AW-1:0]     rd_ptr   [NUM_IN];
   logic [CNTW-1:0]   count    [NUM_IN];
   logic [CNTW-1:0]   count_nx [NUM_IN];

   logic [NUM_IN-1:0] push;
   logic [NUM_IN-1:0] pop;
   logic [NUM_IN-1:0] empty;
   logic [NUM_IN-1:0] elig;
   logic [CW-1:0]     rr;
   logic [CW-1:0]     grant_idx;
   logic              grant_valid;
   logic              load;
   logic [DWIDTH:0]   head;
   int                cand;

   assign load = !out_valid || out_ready;

   always_comb begin
      push  = '0;
      empty = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         push[i]  = in_valid[i] && in_ready[i];
         empty[i] = (count[i] == '0);
      end
   end

`ifdef ARB_N_PKT_LOCK_EN
   logic          lock;
   logic [CW-1:0] lock_chan;

   // While a packet is open only its channel may be granted; an empty locked
   // FIFO stalls the output instead of letting another channel in.
   always_comb begin
      elig = ~empty;
      if (lock) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (CW'(i) != lock_chan) elig[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock      <= 1'b0;
         lock_chan <= '0;
      end else if (load && grant_valid) begin
         lock      <= !head[DWIDTH];
         lock_chan <= grant_idx;
      end
   end
`else
   always_comb elig = ~empty;
`endif

   // Search starts one past the last granted channel
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 1; k <= NUM_IN; k++) begin
         cand = (int'(rr) + k) % NUM_IN;
         if (!grant_valid && elig[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = CW'(cand);
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         pop[i]      = load && grant_valid && (grant_idx == CW'(i));
         count_nx[i] = count[i] + CNTW'(push[i]) - CNTW'(pop[i]);
      end
   end

   assign head = mem[grant_idx][rd_ptr[grant_idx]];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_IN; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= {in_last[i], in_data[i*DWIDTH +: DWIDTH]};
      end
   end

   // in_ready is registered from the next count so it is low through reset
   // and follows a fill/free one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_IN; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         in_ready <= '0;
      end else begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
            count[i]    <= count_nx[i];
            in_ready[i] <= (count_nx[i] != CNTW'(DEPTH));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_chan  <= '0;
         rr        <= CW'(NUM_IN - 1);
      end else if (load) begin
         if (grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= head[DWIDTH-1:0];
            out_last  <= head[DWIDTH];
            out_chan  <= grant_idx;
            rr        <= grant_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
